// File: rtl/down_counter_timer.sv
// Loadable down-counter timer: accepts a start value via valid/ready,
// counts it down to zero and pulses done for one cycle.
//
//   state | meaning
//   ------+-------------------------------------------------------
//   IDLE  | waiting for a load; count is 0, load_ready high
//   RUN   | counting down (or holding on pause); busy high
//   DONE  | terminal count reached; done high for one cycle
module down_counter_timer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [W-1:0] load_value,
   input  logic         pause,
   input  logic         abort,
   output logic [W-1:0] count,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [W-1:0] ZERO = '0;
   localparam logic [W-1:0] ONE  = W'(1);

   state_t         state_q, state_d;
   logic [W-1:0]   count_q, count_d;

   // property bookkeeping: last accepted load was all-ones, and done history
   logic           last_load_ones_q;
   logic           done_prev_q;

   // state and count registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= ZERO;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // next-state and next-count decode; abort beats pause beats decrement
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      unique case (state_q)
         IDLE: begin
            count_d = ZERO;
            if (load_valid) begin
               if (load_value != ZERO) begin
                  count_d = load_value;
                  state_d = RUN;
               end else begin
                  state_d = DONE;
               end
            end
         end
         RUN: begin
            if (abort) begin
               count_d = ZERO;
               state_d = IDLE;
            end else if (pause) begin
               count_d = count_q;
            end else if (count_q == ONE) begin
               count_d = ZERO;
               state_d = DONE;
            end else begin
               // count_q >= 2 here, so the decrement can never wrap
               count_d = count_q - ONE;
            end
         end
         DONE: begin
            count_d = ZERO;
            state_d = IDLE;
         end
         default: begin
            count_d = ZERO;
            state_d = IDLE;
         end
      endcase
   end

   assign load_ready = (state_q == IDLE);
   assign busy       = (state_q == RUN);
   assign done       = (state_q == DONE);
   assign count      = count_q;

   // track history needed by the safety properties
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_load_ones_q <= 1'b0;
         done_prev_q      <= 1'b0;
      end else begin
         if (load_valid && load_ready)
            last_load_ones_q <= &load_value;
         done_prev_q <= done;
      end
   end

   // embedded safety properties, sampled on every rising edge out of reset
   always @(posedge clk) begin
      if (!rst) begin
         p0: assert (!(state_q == IDLE) || (count_q == ZERO));
         p1: assert (!done || (count_q == ZERO));
         p2: assert (!busy || (count_q != ZERO));
         p3: assert (!(&count_q) || last_load_ones_q);
         p4: assert (!(done && done_prev_q));
      end
   end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable down-counter. Accepts a start value through a valid/ready load handshake, decrements it to zero, then emits a one-cycle done pulse.
- It is the count-down counterpart of the team's free-running up-counter and is used as a delay/timeout element.
- It carries embedded immediate assertions so it can be handed directly to the model checker as a safety benchmark.

Parameters:
- W, 10, width of the count and load value in bits (W >= 2).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high; clears all state immediately.
- load_valid  input  1  a start value is offered.
- load_ready  output  1  block can accept a load; high only in IDLE.
- load_value  input  W  start value, sampled when load_valid && load_ready.
- pause  input  1  while high in RUN, count holds.
- abort  input  1  while in RUN, cancels the operation without done.
- count  output  W  current remaining count, registered.
- busy  output  1  high exactly while state is RUN.
- done  output  1  one-cycle pulse, high exactly while state is DONE.

Behaviour:
- All outputs are registered or decoded from registered state.
- States are IDLE, RUN and DONE. Reset (async, rst=1) forces state=IDLE and count=0, giving load_ready=1, busy=0, done=0.
- IDLE:
  - load_ready=1.
  - On an edge with load_valid=1 and load_value!=0: count<=load_value, go to RUN.
  - On an edge with load_valid=1 and load_value==0: count<=0, go to DONE.
  - Otherwise hold; count stays 0.
  - pause and abort are ignored in IDLE.
- RUN (load_ready=0, busy=1). Priority per edge is abort > pause > decrement:
  - abort=1: count<=0, go to IDLE; no done pulse.
  - else pause=1: count and state hold.
  - else if count==1: count<=0, go to DONE.
  - else: count<=count-1.
- DONE (done=1, count=0, load_ready=0): unconditionally go to IDLE on the next edge. A load offered during DONE is not accepted; the source must hold load_valid until load_ready.
- Latency: a load of N>0 accepted at edge 0 with no pauses gives count=N after edge 0, count=0 and done=1 after edge N, and IDLE after edge N+1. Each paused cycle adds exactly one cycle. A load of 0 gives done=1 after edge 0.
- Arithmetic: the decrement is modulo 2^W but must never be applied at count==0. count never wraps to all-ones.
- Loads are accepted back-to-back at most every N+2 cycles; IDLE always lasts at least one cycle.
- Reset mid-RUN or mid-DONE: immediate return to IDLE with count=0 and no done pulse, even if done was high.
- Embedded properties, checked on each posedge while rst=0:
  - p0: state==IDLE implies count==0.
  - p1: done implies count==0.
  - p2: busy implies count!=0.
  - p3: count never equals all-ones unless the last accepted load_value was all-ones.
  - p4: done is never high on two consecutive cycles.
- Environment constraint: rst is asserted in the initial state.

Test Plan:
- Load 5, no pause: after the accept edge count goes 5,4,3,2,1,0; done=1 for exactly one cycle at the edge-5 state; load_ready returns to 1 one cycle later.
- Load 5 with pause high for 3 cycles while count=3: count holds at 3 for 3 cycles; done arrives 3 cycles later than in the unpaused case.
- Load 7, assert abort and pause together at count=4: next cycle state=IDLE, count=0, done never asserts.
- Load 0: done=1 on the cycle directly after the accept; busy never asserts; then IDLE.
- Load 2^W-1 (1023 for W=10): count reaches 0 after 1023 decrements with no wrap; p0-p4 hold throughout.
- Raise rst asynchronously mid-RUN at count=6, and again while done=1: outputs clear immediately to count=0, busy=0, done=0, load_ready=1; a new load of 2 after release completes normally.
